sram_note_fetch: RTL and testbench

Read-only fetch stage between the board SRAM and the note sequencer. It walks the song image from address 0 and reads 16-bit note words through the asynchronous SRAM with a programmable wait-state count. Words are buffered in a small show-ahead FIFO, so the sequencer can pull the next note on its beat boundary without stalling. It stops, or loops back to address 0, on an end-of-song marker word.

---
 rtl/sram_note_fetch_if.sv | 32 +++
 rtl/sram_note_fetch.sv | 143 ++++++++++++++
 tb/tb_sram_note_fetch.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_note_fetch_if.sv
// Bus bundle for the note fetcher: asynchronous SRAM read port plus the
// show-ahead note stream toward the sequencer.
interface sram_note_fetch_if #(
    parameter int ADDR_W = 18
);
    logic              SRAM_CE;
    logic              SRAM_OE;
    logic              SRAM_LB;
    logic              SRAM_UB;
    logic              SRAM_WE;
    logic [ADDR_W-1:0] SRAM_A;
    logic [15:0]       SRAM_D;

    logic              INS_VALID;
    logic              INS_READY;
    logic [15:0]       INS_DATA;
    logic [ADDR_W-1:0] INS_ADDR;

    modport master (
        output SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_WE, SRAM_A,
        input  SRAM_D,
        output INS_VALID, INS_DATA, INS_ADDR,
        input  INS_READY
    );

    modport slave (
        input  SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_WE, SRAM_A,
        output SRAM_D,
        input  INS_VALID, INS_DATA, INS_ADDR,
        output INS_READY
    );
endinterface

// File: rtl/sram_note_fetch.sv
// Read-only song fetcher: walks the SRAM from address 0 with programmable wait
// states and queues note words in a show-ahead FIFO until the end marker.
module sram_note_fetch #(
    parameter int          ADDR_W      = 18,
    parameter int          DEPTH       = 4,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] END_WORD    = 16'hFFFF,
    parameter int          LOOP        = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    sram_note_fetch_if.master          bus,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       DONE
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_CAPTURE,
        ST_HOLD,
        ST_END
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [LVL_W-1:0]   level, level_nx;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [15:0]        mem_data [DEPTH];
    logic [ADDR_W-1:0]  mem_addr [DEPTH];
    logic               done_q;
    logic               word_is_end;
    logic               push;
    logic               pop;

    assign word_is_end = (bus.SRAM_D == END_WORD);
    assign push        = (state == ST_CAPTURE) && !word_is_end;
    assign pop         = (level != '0) && bus.INS_READY;

    // SRAM_A is the program counter itself, so it settles on the new address
    // as SETUP begins and stays put through CAPTURE (and while in HOLD).
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = cnt;
        level_nx = level;
        if (push && !pop) begin
            level_nx = level + 1'b1;
        end else if (!push && pop) begin
            level_nx = level - 1'b1;
        end
        case (state)
            ST_IDLE: begin
                if (START) begin
                    pc_nx    = '0;
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_nx   = CNT_W'(WAIT_CYCLES);
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nx = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!word_is_end) begin
                    pc_nx    = pc + 1'b1;
                    state_nx = (level_nx < FULL) ? ST_SETUP : ST_HOLD;
                end else if (LOOP != 0) begin
                    pc_nx    = '0;
                    state_nx = ST_SETUP;
                end else begin
                    state_nx = ST_END;
                end
            end
            ST_HOLD: begin
                if (level < FULL) begin
                    state_nx = ST_SETUP;
                end
            end
            ST_END: begin
                if (START) begin
                    pc_nx    = '0;
                    state_nx = ST_SETUP;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            pc     <= '0;
            cnt    <= '0;
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            done_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            cnt    <= cnt_nx;
            level  <= level_nx;
            done_q <= (state_nx == ST_END) && (level_nx == '0);
            if (push) begin
                mem_data[wr_ptr] <= bus.SRAM_D;
                mem_addr[wr_ptr] <= pc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign bus.SRAM_CE   = 1'b0;
    assign bus.SRAM_OE   = 1'b0;
    assign bus.SRAM_LB   = 1'b0;
    assign bus.SRAM_UB   = 1'b0;
    assign bus.SRAM_WE   = 1'b1;
    assign bus.SRAM_A    = pc;
    assign bus.INS_VALID = (level != '0);
    assign bus.INS_DATA  = mem_data[rd_ptr];
    assign bus.INS_ADDR  = mem_addr[rd_ptr];
    assign LEVEL         = level;
    assign DONE          = done_q;
endmodule

// File: tb/tb_sram_note_fetch.sv
// Directed bench for sram_note_fetch: cycle table for a basic fetch plus
// hand sequences for backpressure, reset, START handling and looping.
module tb_sram_note_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [2:0]  level;
    logic        done;
    logic [15:0] img [64];

    logic        l_start;
    logic        l_ready;
    logic [2:0]  l_level;
    logic        l_done;
    logic [15:0] img_l [64];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sram_note_fetch_if #(.ADDR_W(18)) bus ();
    sram_note_fetch_if #(.ADDR_W(18)) bus_l ();

    assign bus.SRAM_D     = img[bus.SRAM_A[5:0]];
    assign bus.INS_READY  = ready;
    assign bus_l.SRAM_D   = img_l[bus_l.SRAM_A[5:0]];
    assign bus_l.INS_READY = l_ready;

    sram_note_fetch #(
        .ADDR_W(18), .DEPTH(4), .WAIT_CYCLES(2), .END_WORD(16'hFFFF), .LOOP(0)
    ) dut (
        .CLK(clk), .RST(rst), .START(start), .bus(bus), .LEVEL(level), .DONE(done)
    );

    sram_note_fetch #(
        .ADDR_W(18), .DEPTH(4), .WAIT_CYCLES(2), .END_WORD(16'hFFFF), .LOOP(1)
    ) dut_loop (
        .CLK(clk), .RST(rst), .START(l_start), .bus(bus_l), .LEVEL(l_level), .DONE(l_done)
    );

    typedef struct packed {
        logic        start;
        logic        ready;
        logic        valid;
        logic [15:0] data;
        logic [17:0] addr;
        logic [2:0]  level;
        logic        done;
        logic [17:0] sa;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int lvl, input int maxc, input string nm);
        int n = 0;
        while (level != 3'(lvl) && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, level, lvl);
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int n = 0;
        while (!done && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, done, 1);
    endtask

    // Pop scoreboard and occupancy tracker for the main instance
    logic [33:0] expq [$];
    logic        sb_en = 1'b0;
    logic        trk_en = 1'b0;
    int          lvl_max = 0;

    always @(negedge clk) begin
        if (sb_en && bus.INS_VALID && ready) begin
            if (expq.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL sb_extra: unexpected word %h at %h", bus.INS_DATA, bus.INS_ADDR);
            end else begin
                chk("sb_word", {bus.INS_DATA, bus.INS_ADDR}, expq.pop_front());
            end
        end
        if (trk_en && int'(level) > lvl_max) lvl_max = int'(level);
    end

    logic l_en = 1'b0;
    int   l_pops = 0;
    logic l_done_seen = 1'b0;

    always @(negedge clk) begin
        if (l_en) begin
            if (bus_l.INS_VALID && l_ready) begin
                chk("loop_word", {bus_l.INS_DATA, bus_l.INS_ADDR}, {16'h0001, 18'h0});
                l_pops++;
            end
            if (l_done) l_done_seen = 1'b1;
        end
    end

    initial begin
        //            start ready valid data    addr level done sa
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h3, 18'd0, 3'd1, 1'b0, 18'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h7, 18'd1, 3'd1, 1'b0, 18'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd2};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16'hB, 18'd2, 3'd1, 1'b0, 18'd3};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd3};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd3};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b0, 18'd3};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b1, 18'd3};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0, 18'd0, 3'd0, 1'b1, 18'd3};

        for (int i = 0; i < 64; i++) begin
            img[i]   = 16'hFFFF;
            img_l[i] = 16'hFFFF;
        end
        img[0] = 16'h0003;
        img[1] = 16'h0007;
        img[2] = 16'h000B;
        img_l[0] = 16'h0001;

        rst = 1'b1; start = 1'b0; ready = 1'b0; l_start = 1'b0; l_ready = 1'b0;
        tick();
        tick();
        chk("rst_level", level, 0);
        chk("rst_valid", bus.INS_VALID, 0);
        chk("rst_sram_a", bus.SRAM_A, 0);
        chk("rst_head", {bus.INS_DATA, bus.INS_ADDR}, 0);
        chk("rst_done", done, 0);
        chk("sram_ctrl", {bus.SRAM_CE, bus.SRAM_OE, bus.SRAM_LB, bus.SRAM_UB, bus.SRAM_WE}, 5'b00001);
        rst = 1'b0;
        tick();

        // Basic fetch, cycle by cycle
        for (int i = 0; i < 18; i++) begin
            start = vecs[i].start;
            ready = vecs[i].ready;
            tick();
            chk($sformatf("v%0d.valid", i), bus.INS_VALID, vecs[i].valid);
            chk($sformatf("v%0d.level", i), level, vecs[i].level);
            chk($sformatf("v%0d.done", i), done, vecs[i].done);
            chk($sformatf("v%0d.sram_a", i), bus.SRAM_A, vecs[i].sa);
            if (vecs[i].valid) begin
                chk($sformatf("v%0d.head", i), {bus.INS_DATA, bus.INS_ADDR},
                    {vecs[i].data, vecs[i].addr});
            end
        end
        start = 1'b0;

        // Backpressure on a long song
        for (int i = 0; i < 64; i++) img[i] = 16'h0100 + 16'(i);
        img[40] = 16'hFFFF;
        ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_level(4, 40, "bp_fill");
        chk("bp_sram_a", bus.SRAM_A, 4);
        chk("bp_head", {bus.INS_DATA, bus.INS_ADDR}, {16'h0100, 18'd0});
        repeat (6) tick();
        chk("bp_hold_level", level, 4);
        chk("bp_hold_sram_a", bus.SRAM_A, 4);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("bp_pop_level", level, 3);
        chk("bp_pop_head", {bus.INS_DATA, bus.INS_ADDR}, {16'h0101, 18'd1});
        wait_level(4, 20, "bp_refill");
        chk("bp_refill_sram_a", bus.SRAM_A, 5);

        // Pop timed to land on the CAPTURE edge of the resumed fetch
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("pp_pop_level", level, 3);
        chk("pp_pop_head", {bus.INS_DATA, bus.INS_ADDR}, {16'h0102, 18'd2});
        repeat (4) tick();
        chk("pp_pre_level", level, 3);
        ready = 1'b1;
        tick();
        chk("pp_level", level, 3);
        chk("pp_head", {bus.INS_DATA, bus.INS_ADDR}, {16'h0103, 18'd3});
        chk("pp_sram_a", bus.SRAM_A, 6);

        // Drain with the consumer always ready
        for (int a = 3; a < 40; a++) expq.push_back({16'h0100 + 16'(a), 18'(a)});
        sb_en = 1'b1;
        wait_level(0, 20, "drain_empty");
        lvl_max = 0;
        trk_en = 1'b1;
        wait_done(400, "drain_done");
        trk_en = 1'b0;
        sb_en = 1'b0;
        chk("max_level", lvl_max, 1);
        chk("drain_left", expq.size(), 0);

        // Reset while a read is in flight with two words queued
        ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_level(2, 30, "rst_fill");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", bus.INS_VALID, 0);
        chk("mid_rst_sram_a", bus.SRAM_A, 0);
        chk("mid_rst_head", {bus.INS_DATA, bus.INS_ADDR}, 0);
        chk("mid_rst_done", done, 0);
        repeat (10) tick();
        chk("idle_level", level, 0);
        chk("idle_valid", bus.INS_VALID, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("resume_early", bus.INS_VALID, 0);
        tick();
        chk("resume_valid", bus.INS_VALID, 1);
        chk("resume_head", {bus.INS_DATA, bus.INS_ADDR}, {16'h0100, 18'd0});
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // START ignored mid-fetch, then honoured in END with words queued
        img[0] = 16'h0011;
        img[1] = 16'h0022;
        img[2] = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_sram_a", bus.SRAM_A, 1);
        chk("ign_level", level, 1);
        repeat (8) tick();
        chk("end_level", level, 2);
        chk("end_done", done, 0);
        chk("end_sram_a", bus.SRAM_A, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        expq.push_back({16'h0011, 18'd0});
        expq.push_back({16'h0022, 18'd1});
        expq.push_back({16'h0011, 18'd0});
        expq.push_back({16'h0022, 18'd1});
        ready = 1'b1;
        sb_en = 1'b1;
        wait_done(80, "restart_done");
        sb_en = 1'b0;
        chk("restart_left", expq.size(), 0);

        // Looping instance
        l_en = 1'b1; l_ready = 1'b1; l_start = 1'b1;
        tick();
        l_start = 1'b0;
        repeat (100) tick();
        l_en = 1'b0;
        chk("loop_pops", l_pops >= 8, 1);
        chk("loop_done", l_done_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
